// File: rtl/uart_cmd_parser.sv
// Frames UART RX bytes into ALU/echo command beats with opcode/length validation.
// Optional inter-byte timeout is enabled by defining UART_CMD_PARSER_TIMEOUT_EN.
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [7:0]  cmd_opcode,
   output logic [31:0] cmd_operand,
   output logic        cmd_first,
   output logic        cmd_last,
   output logic        err_o,
   output logic [1:0]  err_code
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RSV,
      S_LEN_L,
      S_LEN_H,
      S_PAYLOAD,
      S_DRAIN
   } state_t;

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hA8;
   localparam logic [7:0] OP_MUL  = 8'hAD;
   localparam logic [7:0] OP_DIV  = 8'hAE;

   state_t      r_state, w_state_nx;
   logic        r_rdy_en;
   logic [7:0]  r_opcode, w_opcode_nx;
   logic        r_op_bad, w_op_bad_nx;
   logic [7:0]  r_len_lo, w_len_lo_nx;
   logic [15:0] r_remain, w_remain_nx;
   logic [23:0] r_shift, w_shift_nx;
   logic [1:0]  r_bcnt, w_bcnt_nx;
   logic        r_first, w_first_nx;

   logic        r_cmd_valid;
   logic [7:0]  r_cmd_opcode;
   logic [31:0] r_cmd_operand;
   logic        r_cmd_first;
   logic        r_cmd_last;
   logic        r_err, w_err_nx;
   logic [1:0]  r_err_code, w_code_nx;

   logic        w_stall;
   logic        w_tready;
   logic        w_accept;
   logic [15:0] w_length;
   logic [15:0] w_payload;
   logic        w_is_echo;
   logic        w_len_short;
   logic        w_len_bad;
   logic        w_load;
   logic [31:0] w_ld_operand;
   logic        w_ld_last;
   logic        w_timeout;

   assign w_stall     = r_cmd_valid && !cmd_ready;
   assign w_tready    = r_rdy_en && !((r_state == S_PAYLOAD) && w_stall);
   assign w_accept    = s_axis_tvalid && w_tready;
   assign w_length    = {s_axis_tdata, r_len_lo};
   assign w_payload   = w_length - 16'd4;
   assign w_is_echo   = (r_opcode == OP_ECHO);
   assign w_len_short = (w_length < 16'd4);
   // Opcode validity is handled separately and takes precedence, so non-echo means arithmetic here.
   assign w_len_bad   = w_len_short ||
                        (!w_is_echo && ((w_payload < 16'd8) || (w_payload[1:0] != 2'b00)));

`ifdef UART_CMD_PARSER_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] r_to_cnt;
   logic            w_to_run;

   assign w_to_run  = (r_state != S_IDLE) && !w_stall && !w_accept;
   assign w_timeout = w_to_run && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_cnt <= '0;
      end else if (w_accept || w_timeout || (r_state == S_IDLE)) begin
         r_to_cnt <= '0;
      end else if (w_to_run) begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end
`else
   // Parameter still referenced so both builds elaborate identically; never fires.
   assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      w_state_nx   = r_state;
      w_opcode_nx  = r_opcode;
      w_op_bad_nx  = r_op_bad;
      w_len_lo_nx  = r_len_lo;
      w_remain_nx  = r_remain;
      w_shift_nx   = r_shift;
      w_bcnt_nx    = r_bcnt;
      w_first_nx   = r_first;
      w_load       = 1'b0;
      w_ld_operand = '0;
      w_ld_last    = 1'b0;
      w_err_nx     = 1'b0;
      w_code_nx    = r_err_code;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_opcode_nx = s_axis_tdata;
               w_op_bad_nx = !((s_axis_tdata == OP_ECHO) || (s_axis_tdata == OP_ADD) ||
                               (s_axis_tdata == OP_MUL)  || (s_axis_tdata == OP_DIV));
               w_state_nx  = S_RSV;
            end
         end
         S_RSV: begin
            if (w_accept) w_state_nx = S_LEN_L;
         end
         S_LEN_L: begin
            if (w_accept) begin
               w_len_lo_nx = s_axis_tdata;
               w_state_nx  = S_LEN_H;
            end
         end
         S_LEN_H: begin
            if (w_accept) begin
               w_remain_nx = w_payload;
               w_bcnt_nx   = '0;
               w_shift_nx  = '0;
               w_first_nx  = 1'b1;
               if (r_op_bad || w_len_bad) begin
                  w_err_nx   = 1'b1;
                  w_code_nx  = r_op_bad ? 2'd1 : 2'd2;
                  w_state_nx = (w_len_short || (w_payload == 16'd0)) ? S_IDLE : S_DRAIN;
               end else if (w_payload == 16'd0) begin
                  w_state_nx = S_IDLE;
               end else begin
                  w_state_nx = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (w_accept) begin
               w_remain_nx = r_remain - 16'd1;
               w_bcnt_nx   = r_bcnt + 2'd1;
               w_shift_nx  = {s_axis_tdata, r_shift[23:8]};
               if (w_is_echo || (r_bcnt == 2'd3)) begin
                  w_load       = 1'b1;
                  w_ld_operand = w_is_echo ? {24'h0, s_axis_tdata} : {s_axis_tdata, r_shift};
                  w_ld_last    = (r_remain == 16'd1);
                  w_first_nx   = 1'b0;
               end
               if (r_remain == 16'd1) w_state_nx = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (w_accept) begin
               w_remain_nx = r_remain - 16'd1;
               if (r_remain == 16'd1) w_state_nx = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase

      if (w_timeout) begin
         w_state_nx = S_IDLE;
         w_err_nx   = 1'b1;
         w_code_nx  = 2'd3;
         w_bcnt_nx  = '0;
         w_shift_nx = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_rdy_en      <= 1'b0;
         r_opcode      <= '0;
         r_op_bad      <= 1'b0;
         r_len_lo      <= '0;
         r_remain      <= '0;
         r_shift       <= '0;
         r_bcnt        <= '0;
         r_first       <= 1'b0;
         r_cmd_valid   <= 1'b0;
         r_cmd_opcode  <= '0;
         r_cmd_operand <= '0;
         r_cmd_first   <= 1'b0;
         r_cmd_last    <= 1'b0;
         r_err         <= 1'b0;
         r_err_code    <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_rdy_en   <= 1'b1;
         r_opcode   <= w_opcode_nx;
         r_op_bad   <= w_op_bad_nx;
         r_len_lo   <= w_len_lo_nx;
         r_remain   <= w_remain_nx;
         r_shift    <= w_shift_nx;
         r_bcnt     <= w_bcnt_nx;
         r_first    <= w_first_nx;
         r_err      <= w_err_nx;
         r_err_code <= w_code_nx;
         if (w_load) begin
            r_cmd_valid   <= 1'b1;
            r_cmd_opcode  <= r_opcode;
            r_cmd_operand <= w_ld_operand;
            r_cmd_first   <= r_first;
            r_cmd_last    <= w_ld_last;
         end else if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
         end
      end
   end

   assign s_axis_tready = w_tready;
   assign cmd_valid     = r_cmd_valid;
   assign cmd_opcode    = r_cmd_opcode;
   assign cmd_operand   = r_cmd_operand;
   assign cmd_first     = r_cmd_first;
   assign cmd_last      = r_cmd_last;
   assign err_o         = r_err;
   assign err_code      = r_err_code;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed scenarios plus randomized packets against a packet-level model.
module tb_uart_cmd_parser;

   localparam int unsigned TO_CYC = 50;

   logic        clk;
   logic        rst;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_opcode;
   logic [31:0] cmd_operand;
   logic        cmd_first;
   logic        cmd_last;
   logic        err_o;
   logic [1:0]  err_code;

   uart_cmd_parser #(.TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_opcode    (cmd_opcode),
      .cmd_operand   (cmd_operand),
      .cmd_first     (cmd_first),
      .cmd_last      (cmd_last),
      .err_o         (err_o),
      .err_code      (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  op;
      logic [31:0] val;
      logic        first;
      logic        last;
   } beat_t;

   beat_t       got_q[$];
   beat_t       exp_q[$];
   logic [1:0]  got_err[$];
   logic [1:0]  exp_err[$];
   logic [7:0]  pkt[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int unsigned n_acc = 0;
   int          ready_mode = 0;   // 0 = ready high, 1 = random, 2 = held low

   function automatic beat_t mk(input logic [7:0] op, input logic [31:0] val,
                                input logic f, input logic l);
      beat_t b;
      b.op = op; b.val = val; b.first = f; b.last = l;
      return b;
   endfunction

   initial begin
      cmd_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         case (ready_mode)
            0:       cmd_ready = 1'b1;
            1:       cmd_ready = 1'($urandom_range(0, 1));
            default: cmd_ready = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_valid && cmd_ready) got_q.push_back(mk(cmd_opcode, cmd_operand, cmd_first, cmd_last));
         if (err_o) got_err.push_back(err_code);
         if (s_axis_tvalid && s_axis_tready) n_acc++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running required finished");
      $fatal(1);
   end

   task automatic clear_sb();
      got_q.delete(); exp_q.delete(); got_err.delete(); exp_err.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int unsigned n;
      n = 0;
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      while (!s_axis_tready && n < 500) begin @(negedge clk); n++; end
      if (!s_axis_tready) begin
         n_cmp++; n_fail++;
         $display("FAIL send_byte: tready got 0 required 1 within 500 cycles");
      end
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_pkt(input int unsigned gap_max);
      foreach (pkt[i]) begin
         send_byte(pkt[i]);
         if (gap_max != 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_idle();
      int unsigned n;
      n = 0;
      ready_mode = 0;
      @(negedge clk);
      while (cmd_valid && n < 300) begin @(negedge clk); n++; end
      if (cmd_valid) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_idle: cmd_valid got 1 required 0 within 300 cycles");
      end
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
   endtask

   // Packet-level reference: derives beats and errors straight from the packet rules.
   function automatic void model_pkt();
      logic [7:0]  op;
      logic [15:0] len;
      int unsigned pay;
      bit          echo, arith;
      op    = pkt[0];
      len   = {pkt[3], pkt[2]};
      echo  = (op == 8'hEC);
      arith = (op == 8'hA8) || (op == 8'hAD) || (op == 8'hAE);
      if (!echo && !arith) begin exp_err.push_back(2'd1); return; end
      if (len < 16'd4) begin exp_err.push_back(2'd2); return; end
      pay = int'(len) - 4;
      if (arith && (pay < 8 || pay % 4 != 0)) begin exp_err.push_back(2'd2); return; end
      if (echo) begin
         for (int i = 0; i < int'(pay); i++)
            exp_q.push_back(mk(op, {24'h0, pkt[4+i]}, i == 0, i == int'(pay) - 1));
      end else begin
         for (int k = 0; k < int'(pay / 4); k++)
            exp_q.push_back(mk(op, {pkt[7+4*k], pkt[6+4*k], pkt[5+4*k], pkt[4+4*k]},
                               k == 0, k == int'(pay / 4) - 1));
      end
   endfunction

   task automatic build_random();
      int unsigned kind, pay;
      logic [15:0] len;
      logic [7:0]  op;
      kind = $urandom_range(0, 4);
      pay  = 0;
      case (kind)
         0: begin op = 8'hEC; pay = $urandom_range(0, 6); end
         1: begin
            op  = ($urandom_range(0, 2) == 0) ? 8'hA8 : (($urandom_range(0, 1) == 0) ? 8'hAD : 8'hAE);
            pay = 4 * $urandom_range(2, 4);
         end
         2: begin
            do op = 8'($urandom); while (op inside {8'hEC, 8'hA8, 8'hAD, 8'hAE});
            pay = $urandom_range(0, 5);
         end
         3: begin
            op  = 8'hA8;
            pay = $urandom_range(0, 13);
            if (pay >= 8 && pay % 4 == 0) pay++;
         end
         default: op = ($urandom_range(0, 1) == 1) ? 8'hEC : 8'($urandom);
      endcase
      len = (kind == 4) ? 16'($urandom_range(0, 3)) : 16'(pay + 4);
      pkt.delete();
      pkt.push_back(op);
      pkt.push_back(8'($urandom));
      pkt.push_back(len[7:0]);
      pkt.push_back(len[15:8]);
      repeat (pay) pkt.push_back(8'($urandom));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b required 0", s_axis_tready); end
      n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", cmd_valid); end
      n_cmp++; if (cmd_opcode !== 8'h0) begin n_fail++; $display("FAIL reset_opcode: got %h required 00", cmd_opcode); end
      n_cmp++; if (cmd_operand !== 32'h0) begin n_fail++; $display("FAIL reset_operand: got %h required 0", cmd_operand); end
      n_cmp++; if ({cmd_first, cmd_last} !== 2'b00) begin n_fail++; $display("FAIL reset_first_last: got %b required 00", {cmd_first, cmd_last}); end
      n_cmp++; if ({err_o, err_code} !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b required 000", {err_o, err_code}); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL tready_release_edge: got %b required 0", s_axis_tready); end
      @(negedge clk);
      n_cmp++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL tready_after_reset: got %b required 1", s_axis_tready); end
      @(posedge clk); #1;
   endtask

   task automatic test_echo();
      clear_sb();
      pkt = '{8'hEC, 8'h00, 8'h06, 8'h00};
      send_pkt(0);
      send_byte(8'h41);
      @(negedge clk);
      n_cmp++; if ({cmd_valid, cmd_operand, cmd_first} !== {1'b1, 32'h41, 1'b1}) begin
         n_fail++; $display("FAIL echo_latency: got v=%b op=%h f=%b required v=1 op=41 f=1", cmd_valid, cmd_operand, cmd_first);
      end
      @(posedge clk); #1;
      send_byte(8'h42);
      wait_idle();
      n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("FAIL echo_count: got %0d required 2", got_q.size()); end
      n_cmp++; if (got_q[0] !== mk(8'hEC, 32'h41, 1'b1, 1'b0)) begin n_fail++; $display("FAIL echo_beat0: got %h required %h", got_q[0], mk(8'hEC, 32'h41, 1'b1, 1'b0)); end
      n_cmp++; if (got_q[1] !== mk(8'hEC, 32'h42, 1'b0, 1'b1)) begin n_fail++; $display("FAIL echo_beat1: got %h required %h", got_q[1], mk(8'hEC, 32'h42, 1'b0, 1'b1)); end
      n_cmp++; if (got_err.size() != 0) begin n_fail++; $display("FAIL echo_err: got %0d errors required 0", got_err.size()); end
   endtask

   task automatic test_add();
      clear_sb();
      pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
      send_pkt(0);
      wait_idle();
      n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("FAIL add_count: got %0d required 2", got_q.size()); end
      n_cmp++; if (got_q[0] !== mk(8'hA8, 32'h1, 1'b1, 1'b0)) begin n_fail++; $display("FAIL add_beat0: got %h required %h", got_q[0], mk(8'hA8, 32'h1, 1'b1, 1'b0)); end
      n_cmp++; if (got_q[1] !== mk(8'hA8, 32'h2, 1'b0, 1'b1)) begin n_fail++; $display("FAIL add_beat1: got %h required %h", got_q[1], mk(8'hA8, 32'h2, 1'b0, 1'b1)); end
   endtask

   task automatic test_backpressure();
      clear_sb();
      pkt = '{8'hAD, 8'h00, 8'h10, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
              8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h04, 8'h03, 8'h02, 8'h01};
      fork
         send_pkt(0);
         begin
            beat_t       cap;
            int unsigned n;
            n = 0;
            @(negedge clk);
            while (!(cmd_valid && cmd_ready && cmd_first) && n < 100) begin @(negedge clk); n++; end
            ready_mode = 2;
            n = 0;
            @(negedge clk);
            while (!cmd_valid && n < 100) begin @(negedge clk); n++; end
            cap = mk(cmd_opcode, cmd_operand, cmd_first, cmd_last);
            n_cmp++; if (cap !== mk(8'hAD, 32'hAABBCCDD, 1'b0, 1'b0)) begin n_fail++; $display("FAIL bp_stalled_beat: got %h required %h", cap, mk(8'hAD, 32'hAABBCCDD, 1'b0, 1'b0)); end
            for (int c = 0; c < 10; c++) begin
               n_cmp++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready[%0d]: got %b required 0", c, s_axis_tready); end
               n_cmp++; if ({cmd_valid, cmd_opcode, cmd_operand, cmd_first, cmd_last} !== {1'b1, cap}) begin
                  n_fail++; $display("FAIL bp_stable[%0d]: got %h required %h", c, {cmd_valid, cmd_opcode, cmd_operand, cmd_first, cmd_last}, {1'b1, cap});
               end
               @(negedge clk);
            end
            ready_mode = 0;
         end
      join
      wait_idle();
      n_cmp++; if (got_q.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d required 3", got_q.size()); end
      n_cmp++; if (got_q[0] !== mk(8'hAD, 32'h11223344, 1'b1, 1'b0)) begin n_fail++; $display("FAIL bp_beat0: got %h required %h", got_q[0], mk(8'hAD, 32'h11223344, 1'b1, 1'b0)); end
      n_cmp++; if (got_q[1] !== mk(8'hAD, 32'hAABBCCDD, 1'b0, 1'b0)) begin n_fail++; $display("FAIL bp_beat1: got %h required %h", got_q[1], mk(8'hAD, 32'hAABBCCDD, 1'b0, 1'b0)); end
      n_cmp++; if (got_q[2] !== mk(8'hAD, 32'h01020304, 1'b0, 1'b1)) begin n_fail++; $display("FAIL bp_beat2: got %h required %h", got_q[2], mk(8'hAD, 32'h01020304, 1'b0, 1'b1)); end
   endtask

   task automatic test_bad_opcode();
      int unsigned acc0;
      clear_sb();
      acc0 = n_acc;
      pkt = '{8'h55, 8'h00, 8'h07, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
      send_pkt(0);
      wait_idle();
      n_cmp++; if (n_acc - acc0 != 12) begin n_fail++; $display("FAIL badop_accepted: got %0d required 12", n_acc - acc0); end
      n_cmp++; if (got_err.size() != 1 || got_err[0] !== 2'd1) begin n_fail++; $display("FAIL badop_err: got n=%0d code=%0d required n=1 code=1", got_err.size(), got_err[0]); end
      n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL badop_count: got %0d required 1", got_q.size()); end
      n_cmp++; if (got_q[0] !== mk(8'hEC, 32'h5A, 1'b1, 1'b1)) begin n_fail++; $display("FAIL badop_resync: got %h required %h", got_q[0], mk(8'hEC, 32'h5A, 1'b1, 1'b1)); end
      n_cmp++; if (err_code !== 2'd1) begin n_fail++; $display("FAIL badop_code_held: got %0d required 1", err_code); end
   endtask

   task automatic test_bad_length();
      int unsigned acc0;
      clear_sb();
      acc0 = n_acc;
      pkt = '{8'hA8, 8'h00, 8'h09, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
              8'hEC, 8'h00, 8'h02, 8'h00, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
      send_pkt(0);
      wait_idle();
      n_cmp++; if (n_acc - acc0 != 18) begin n_fail++; $display("FAIL badlen_accepted: got %0d required 18", n_acc - acc0); end
      n_cmp++; if (got_err.size() != 2) begin n_fail++; $display("FAIL badlen_err_count: got %0d required 2", got_err.size()); end
      n_cmp++; if (got_err[0] !== 2'd2) begin n_fail++; $display("FAIL badlen_code_arith: got %0d required 2", got_err[0]); end
      n_cmp++; if (got_err[1] !== 2'd2) begin n_fail++; $display("FAIL badlen_code_short: got %0d required 2", got_err[1]); end
      n_cmp++; if (got_q.size() != 1 || got_q[0] !== mk(8'hEC, 32'h77, 1'b1, 1'b1)) begin
         n_fail++; $display("FAIL badlen_resync: got n=%0d %h required n=1 %h", got_q.size(), got_q[0], mk(8'hEC, 32'h77, 1'b1, 1'b1));
      end
   endtask

`ifdef UART_CMD_PARSER_TIMEOUT_EN
   task automatic test_timeout();
      clear_sb();
      pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h41};
      send_pkt(0);
      repeat (60) @(posedge clk);
      #1;
      pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
      send_pkt(0);
      wait_idle();
      n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("FAIL to_count: got %0d required 2", got_q.size()); end
      n_cmp++; if (got_q[0] !== mk(8'hEC, 32'h41, 1'b1, 1'b0)) begin n_fail++; $display("FAIL to_beat: got %h required %h", got_q[0], mk(8'hEC, 32'h41, 1'b1, 1'b0)); end
      n_cmp++; if (got_q[1] !== mk(8'hEC, 32'h5A, 1'b1, 1'b1)) begin n_fail++; $display("FAIL to_resync: got %h required %h", got_q[1], mk(8'hEC, 32'h5A, 1'b1, 1'b1)); end
      n_cmp++; if (got_err.size() != 1 || got_err[0] !== 2'd3) begin n_fail++; $display("FAIL to_err: got n=%0d code=%0d required n=1 code=3", got_err.size(), got_err[0]); end
   endtask
`endif

   task automatic test_back_to_back();
      int unsigned acc0, nbytes;
      clear_sb();
      acc0   = n_acc;
      nbytes = 0;
      ready_mode = 1;
      for (int p = 0; p < 40; p++) begin
         build_random();
         model_pkt();
         nbytes += pkt.size();
         send_pkt((p % 2 == 0) ? 0 : 2);
      end
      wait_idle();
      n_cmp++; if (n_acc - acc0 != nbytes) begin n_fail++; $display("FAIL rand_accepted: got %0d required %0d", n_acc - acc0, nbytes); end
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_beat_count: got %0d required %0d", got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
         if (i < got_q.size()) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
         end
      end
      n_cmp++; if (got_err.size() != exp_err.size()) begin n_fail++; $display("FAIL rand_err_count: got %0d required %0d", got_err.size(), exp_err.size()); end
      foreach (exp_err[i]) begin
         if (i < got_err.size()) begin
            n_cmp++; if (got_err[i] !== exp_err[i]) begin n_fail++; $display("FAIL rand_err[%0d]: got %0d required %0d", i, got_err[i], exp_err[i]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      ready_mode = 2;
      @(posedge clk); #1;
      pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
      send_pkt(0);
      @(negedge clk);
      n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending: got %b required 1", cmd_valid); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if ({s_axis_tready, cmd_valid, cmd_first, cmd_last, err_o} !== 5'b0) begin
         n_fail++; $display("FAIL rstmid_ctrl: got %b required 00000", {s_axis_tready, cmd_valid, cmd_first, cmd_last, err_o});
      end
      n_cmp++; if ({cmd_opcode, cmd_operand, err_code} !== 42'h0) begin
         n_fail++; $display("FAIL rstmid_fields: got %h required 0", {cmd_opcode, cmd_operand, err_code});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      ready_mode = 0;
      pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'h77, 8'h88};
      send_pkt(0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_sb();
      pkt = '{8'hA8, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
      send_pkt(0);
      wait_idle();
      n_cmp++; if (got_q.size() != 2 || got_q[0] !== mk(8'hA8, 32'h1, 1'b1, 1'b0) || got_q[1] !== mk(8'hA8, 32'h2, 1'b0, 1'b1)) begin
         n_fail++; $display("FAIL rstmid_reparse: got n=%0d %h %h required n=2 %h %h", got_q.size(), got_q[0], got_q[1],
                            mk(8'hA8, 32'h1, 1'b1, 1'b0), mk(8'hA8, 32'h2, 1'b0, 1'b1));
      end
      n_cmp++; if (got_err.size() != 0) begin n_fail++; $display("FAIL rstmid_err: got %0d errors required 0", got_err.size()); end
   endtask

   initial begin
      rst           = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
      test_reset();
      test_echo();
      test_add();
      test_backpressure();
      test_bad_opcode();
      test_bad_length();
`ifdef UART_CMD_PARSER_TIMEOUT_EN
      test_timeout();
`endif
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
